// File: rtl/ldst_issue_sched.sv
// In-order allocate/issue scheduler for the 4-entry load/store reservation station.
// Optional stall counter enabled with `define LDST_ISSUE_SCHED_STAT_EN.
module ldst_issue_sched #(
  parameter int ENT_NUM = 4,
  parameter int ENT_SEL = 2,
  parameter int CNT_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req1,
  input  logic               req2,
  output logic               allocatable,
  output logic               we1,
  output logic               we2,
  output logic [ENT_SEL-1:0] waddr1,
  output logic [ENT_SEL-1:0] waddr2,
  input  logic [ENT_NUM-1:0] ready,
  input  logic               mem_stall,
  input  logic               prmiss,
  input  logic [ENT_NUM-1:0] prbusyvec_next,
  output logic               issue_valid,
  output logic [ENT_SEL-1:0] issueaddr,
  output logic [CNT_W-1:0]   occupancy
`ifdef LDST_ISSUE_SCHED_STAT_EN
  ,
  input  logic               stat_clr,
  output logic [15:0]        stall_cnt
`endif
);

  logic [ENT_NUM-1:0][ENT_SEL-1:0] qent;
  logic [ENT_SEL-1:0]              head, tail;
  logic [CNT_W-1:0]                cnt;
  logic [ENT_NUM-1:0]              inq;

  logic               f1, f2;
  logic [CNT_W-1:0]   need, k;
  logic [ENT_NUM-1:0] inq_keep, inq_nxt;
  logic [ENT_SEL-1:0] idx;
  logic               alive;

  // Lowest and next-lowest free entries; in-flight issues are not reused this cycle.
  always_comb begin
    waddr1 = '0;
    waddr2 = '0;
    f1     = 1'b0;
    f2     = 1'b0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (!inq[i]) begin
        if (!f1) begin
          waddr1 = ENT_SEL'(i);
          f1     = 1'b1;
        end else if (!f2) begin
          waddr2 = ENT_SEL'(i);
          f2     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    need        = CNT_W'(req1) + CNT_W'(req1 & req2);
    allocatable = (CNT_W'(ENT_NUM) - cnt) >= need;
    we1         = req1 & allocatable & ~prmiss;
    we2         = req1 & req2 & allocatable & ~prmiss;
    issueaddr   = qent[head];
    issue_valid = (cnt != '0) & ready[qent[head]] & ~mem_stall & ~prmiss;
    occupancy   = cnt;
  end

  // Survivors of a mispredict: the run of queue slots from head still busy.
  always_comb begin
    k        = '0;
    inq_keep = '0;
    alive    = 1'b1;
    idx      = head;
    for (int i = 0; i < ENT_NUM; i++) begin
      idx = head + ENT_SEL'(i);
      if (alive && (CNT_W'(i) < cnt) && prbusyvec_next[qent[idx]]) begin
        k                  = k + CNT_W'(1);
        inq_keep[qent[idx]] = 1'b1;
      end else begin
        alive = 1'b0;
      end
    end
  end

  always_comb begin
    inq_nxt = inq;
    if (issue_valid) inq_nxt[qent[head]] = 1'b0;
    if (we1)         inq_nxt[waddr1]     = 1'b1;
    if (we2)         inq_nxt[waddr2]     = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      qent <= '0;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      inq  <= '0;
    end else if (prmiss) begin
      cnt  <= k;
      tail <= head + ENT_SEL'(k);
      inq  <= inq_keep;
    end else begin
      if (we1) qent[tail]                 <= waddr1;
      if (we2) qent[tail + ENT_SEL'(1)]   <= waddr2;
      if (issue_valid) head <= head + ENT_SEL'(1);
      tail <= tail + ENT_SEL'(we1) + ENT_SEL'(we2);
      cnt  <= cnt + CNT_W'(we1) + CNT_W'(we2) - CNT_W'(issue_valid);
      inq  <= inq_nxt;
    end
  end

`ifdef LDST_ISSUE_SCHED_STAT_EN
  always_ff @(posedge clk) begin
    if (!reset || stat_clr)
      stall_cnt <= '0;
    else if ((cnt != '0) && !issue_valid && !prmiss && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ldst_issue_sched.sv
// Directed bench for ldst_issue_sched: allocation, in-order issue, stalls, wrap, mispredict, reset.
module tb_ldst_issue_sched;
  logic       clk = 1'b0;
  logic       reset, req1, req2, mem_stall, prmiss;
  logic [3:0] ready, prbusyvec_next;
  logic       allocatable, we1, we2, issue_valid;
  logic [1:0] waddr1, waddr2, issueaddr;
  logic [2:0] occupancy;
`ifdef LDST_ISSUE_SCHED_STAT_EN
  logic        stat_clr;
  logic [15:0] stall_cnt;
`endif
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ldst_issue_sched dut (
    .clk(clk), .reset(reset), .req1(req1), .req2(req2),
    .allocatable(allocatable), .we1(we1), .we2(we2),
    .waddr1(waddr1), .waddr2(waddr2), .ready(ready),
    .mem_stall(mem_stall), .prmiss(prmiss), .prbusyvec_next(prbusyvec_next),
    .issue_valid(issue_valid), .issueaddr(issueaddr), .occupancy(occupancy)
`ifdef LDST_ISSUE_SCHED_STAT_EN
    , .stat_clr(stat_clr), .stall_cnt(stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req1 = 0; req2 = 0; mem_stall = 0; prmiss = 0;
    ready = 4'h0; prbusyvec_next = 4'h0;
`ifdef LDST_ISSUE_SCHED_STAT_EN
    stat_clr = 1'b0;
`endif
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    ready = 4'hF; #1;
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL reset_iv got %b want 0", issue_valid); end
    tests++; if (allocatable !== 1'b1) begin fails++; $display("FAIL reset_alloc got %b want 1", allocatable); end
    tests++; if (waddr1 !== 2'd0 || waddr2 !== 2'd1) begin fails++; $display("FAIL reset_waddr got %0d/%0d want 0/1", waddr1, waddr2); end
    tests++; if (issueaddr !== 2'd0) begin fails++; $display("FAIL reset_issueaddr got %0d want 0", issueaddr); end
`ifdef LDST_ISSUE_SCHED_STAT_EN
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
`endif
    ready = 4'h0;
  endtask

  task automatic test_alloc_full();
    do_reset();
    req1 = 1; req2 = 1; #1;
    tests++; if ({we1, we2, waddr1, waddr2} !== {2'b11, 2'd0, 2'd1}) begin fails++; $display("FAIL alloc_c1 got we=%b%b wa=%0d/%0d want 11 0/1", we1, we2, waddr1, waddr2); end
    tick();
    tests++; if ({we1, we2, waddr1, waddr2} !== {2'b11, 2'd2, 2'd3}) begin fails++; $display("FAIL alloc_c2 got we=%b%b wa=%0d/%0d want 11 2/3", we1, we2, waddr1, waddr2); end
    tick();
    req2 = 0; #1;
    tests++; if (occupancy !== 3'd4) begin fails++; $display("FAIL alloc_occ got %0d want 4", occupancy); end
    tests++; if (allocatable !== 1'b0 || we1 !== 1'b0) begin fails++; $display("FAIL alloc_full got alloc=%b we1=%b want 0 0", allocatable, we1); end
    req1 = 0;
  endtask

  task automatic test_inorder();
    do_reset();
    req1 = 1; req2 = 1; tick(); tick(); req1 = 0; req2 = 0;
    ready = 4'b1110; #1;
    for (int c = 0; c < 3; c++) begin
      tests++; if (issue_valid !== 1'b0 || issueaddr !== 2'd0) begin fails++; $display("FAIL inorder_block c%0d got iv=%b ia=%0d want 0 0", c, issue_valid, issueaddr); end
      tick();
    end
    ready = 4'b1111; #1;
    for (int e = 0; e < 4; e++) begin
      tests++; if (issue_valid !== 1'b1 || issueaddr !== 2'(e)) begin fails++; $display("FAIL inorder_issue e%0d got iv=%b ia=%0d want 1 %0d", e, issue_valid, issueaddr, e); end
      tick();
    end
    tests++; if (occupancy !== 3'd0 || issue_valid !== 1'b0) begin fails++; $display("FAIL inorder_empty got occ=%0d iv=%b want 0 0", occupancy, issue_valid); end
    ready = 4'h0;
  endtask

  task automatic test_mem_stall();
    do_reset();
    req1 = 1; req2 = 1; tick(); req1 = 0; req2 = 0;
    ready = 4'b0011; mem_stall = 1; #1;
    for (int c = 0; c < 3; c++) begin
      tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL stall_c%0d got iv=%b want 0", c, issue_valid); end
      tick();
    end
    mem_stall = 0; #1;
    tests++; if (issue_valid !== 1'b1 || issueaddr !== 2'd0) begin fails++; $display("FAIL stall_rel0 got iv=%b ia=%0d want 1 0", issue_valid, issueaddr); end
    tick();
    tests++; if (issue_valid !== 1'b1 || issueaddr !== 2'd1) begin fails++; $display("FAIL stall_rel1 got iv=%b ia=%0d want 1 1", issue_valid, issueaddr); end
    tick();
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL stall_occ got %0d want 0", occupancy); end
    ready = 4'h0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req1 = 1; req2 = 1; tick(); req2 = 0; tick();
    ready = 4'b0001; #1;
    tests++; if ({issue_valid, issueaddr, we1, waddr1} !== {1'b1, 2'd0, 1'b1, 2'd3}) begin fails++; $display("FAIL b2b_same got iv=%b ia=%0d we1=%b wa1=%0d want 1 0 1 3", issue_valid, issueaddr, we1, waddr1); end
    tick();
    ready = 4'h0; #1;
    tests++; if (occupancy !== 3'd3) begin fails++; $display("FAIL b2b_occ got %0d want 3", occupancy); end
    tests++; if (we1 !== 1'b1 || waddr1 !== 2'd0) begin fails++; $display("FAIL b2b_reuse got we1=%b wa1=%0d want 1 0", we1, waddr1); end
    tick();
    req1 = 0; #1;
    tests++; if (occupancy !== 3'd4) begin fails++; $display("FAIL b2b_occ2 got %0d want 4", occupancy); end
  endtask

  task automatic test_wrap_prmiss();
    do_reset();
    req1 = 1; req2 = 1; tick(); tick(); req1 = 0; req2 = 0;
    ready = 4'b0011; tick(); tick();
    ready = 4'h0; req1 = 1; req2 = 1; #1;
    tests++; if ({we1, we2, waddr1, waddr2} !== {2'b11, 2'd0, 2'd1}) begin fails++; $display("FAIL wrap_alloc got we=%b%b wa=%0d/%0d want 11 0/1", we1, we2, waddr1, waddr2); end
    tick();
    req2 = 0; req1 = 1; prmiss = 1; prbusyvec_next = 4'b1100; ready = 4'hF; #1;
    tests++; if (occupancy !== 3'd4 || issueaddr !== 2'd2) begin fails++; $display("FAIL wrap_order got occ=%0d ia=%0d want 4 2", occupancy, issueaddr); end
    tests++; if (we1 !== 1'b0 || issue_valid !== 1'b0) begin fails++; $display("FAIL prmiss_block got we1=%b iv=%b want 0 0", we1, issue_valid); end
    tick();
    prmiss = 0; req1 = 0; ready = 4'h0; #1;
    tests++; if (occupancy !== 3'd2 || waddr1 !== 2'd0 || issueaddr !== 2'd2) begin fails++; $display("FAIL prmiss_trim got occ=%0d wa1=%0d ia=%0d want 2 0 2", occupancy, waddr1, issueaddr); end
    ready = 4'hF; #1;
    tests++; if (issue_valid !== 1'b1 || issueaddr !== 2'd2) begin fails++; $display("FAIL prmiss_i2 got iv=%b ia=%0d want 1 2", issue_valid, issueaddr); end
    tick();
    tests++; if (issue_valid !== 1'b1 || issueaddr !== 2'd3) begin fails++; $display("FAIL prmiss_i3 got iv=%b ia=%0d want 1 3", issue_valid, issueaddr); end
    tick();
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL prmiss_end got %0d want 0", occupancy); end
    ready = 4'h0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req1 = 1; req2 = 1; tick(); req2 = 0; tick(); #1;
    tests++; if (occupancy !== 3'd3) begin fails++; $display("FAIL rmid_pre got %0d want 3", occupancy); end
    reset = 0; tick();
    reset = 1; req1 = 0; ready = 4'hF; #1;
    tests++; if (occupancy !== 3'd0 || issue_valid !== 1'b0 || waddr1 !== 2'd0) begin fails++; $display("FAIL rmid got occ=%0d iv=%b wa1=%0d want 0 0 0", occupancy, issue_valid, waddr1); end
    ready = 4'h0;
  endtask

`ifdef LDST_ISSUE_SCHED_STAT_EN
  task automatic test_stat();
    do_reset();
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL stat_rst got %0d want 0", stall_cnt); end
    req1 = 1; tick(); req1 = 0;
    for (int c = 0; c < 5; c++) tick();
    tests++; if (stall_cnt !== 16'd5) begin fails++; $display("FAIL stat_cnt got %0d want 5", stall_cnt); end
    stat_clr = 1; tick(); stat_clr = 0; #1;
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL stat_clr got %0d want 0", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_alloc_full();
    test_inorder();
    test_mem_stall();
    test_back_to_back();
    test_wrap_prmiss();
    test_reset_mid();
`ifdef LDST_ISSUE_SCHED_STAT_EN
    test_stat();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
